// File: rtl/sram_controller.sv
// Multi-cycle MEM-stage data memory: splits each 32-bit word access into two 16-bit accesses
// on an external asynchronous SRAM, holding ready low until the access completes.
module sram_controller #(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dq_out,
  input  logic [15:0] sram_dq_in,
  output logic        sram_dq_oe,
  output logic        sram_we_n
);

  typedef enum logic [1:0] {StIdle, StLo, StHi, StDone} state_e;

  localparam logic [2:0] WaitLast = 3'(WAIT_CYCLES);

  state_e      state_q, state_d;
  logic [2:0]  wcnt_q, wcnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        is_write_q, is_write_d;

  logic        req;
  logic        phase_end;
  logic        in_hi;
  logic [31:0] offset;
  logic        unused_offset_bits;

  assign req       = wr_en | rd_en;
  assign phase_end = (wcnt_q == WaitLast);
  assign in_hi     = (state_q == StHi);
  // Unsigned wrap is intended: out-of-range addresses alias silently.
  assign offset    = addr_q - BASE_ADDR;
  assign unused_offset_bits = ^{offset[31:19], offset[1:0]};
  assign read_data = rdata_q;

  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    is_write_d  = is_write_q;
    rdata_d     = rdata_q;
    ready       = 1'b0;
    sram_addr   = '0;
    sram_dq_out = '0;
    sram_dq_oe  = 1'b0;
    sram_we_n   = 1'b1;

    unique case (state_q)
      StIdle: begin
        ready = !req;
        if (req) begin
          state_d    = StLo;
          wcnt_d     = '0;
          addr_d     = address;
          wdata_d    = write_data;
          is_write_d = wr_en;
        end
      end
      StLo, StHi: begin
        sram_addr = {offset[18:2], in_hi};
        if (is_write_q) begin
          sram_we_n   = 1'b0;
          sram_dq_oe  = 1'b1;
          sram_dq_out = in_hi ? wdata_q[31:16] : wdata_q[15:0];
        end
        if (phase_end) begin
          wcnt_d  = '0;
          state_d = in_hi ? StDone : StHi;
          // Sample on the last cycle of the phase so the SRAM has had the full wait time.
          if (!is_write_q) begin
            if (in_hi) rdata_d[31:16] = sram_dq_in;
            else       rdata_d[15:0]  = sram_dq_in;
          end
        end else begin
          wcnt_d = wcnt_q + 3'd1;
        end
      end
      StDone: begin
        ready   = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      wcnt_q     <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      is_write_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      is_write_q <= is_write_d;
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller: WAIT_CYCLES=1 instance against a behavioural SRAM,
// plus a WAIT_CYCLES=0 instance for stall-length checks.
module tb_sram_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en, rd_en;
  logic [31:0] address, write_data;
  logic [31:0] read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out, sram_dq_in;
  logic        sram_dq_oe, sram_we_n;

  logic        wr_en0, rd_en0;
  logic [31:0] address0, write_data0;
  logic [31:0] read_data0;
  logic        ready0;
  logic [17:0] sram_addr0;
  logic [15:0] sram_dq_out0;
  logic        sram_dq_oe0, sram_we_n0;

  logic [15:0] mem [0:63];

  logic [17:0] rec_addr [0:31];
  logic [15:0] rec_dq   [0:31];
  logic        rec_we   [0:31];
  logic        rec_oe   [0:31];

  int total = 0;
  int bad   = 0;
  int n;

  always #5 clk = ~clk;

  sram_controller #(.WAIT_CYCLES(1), .BASE_ADDR(32'd1024)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .ready      (ready),
    .sram_addr  (sram_addr),
    .sram_dq_out(sram_dq_out),
    .sram_dq_in (sram_dq_in),
    .sram_dq_oe (sram_dq_oe),
    .sram_we_n  (sram_we_n)
  );

  sram_controller #(.WAIT_CYCLES(0), .BASE_ADDR(32'd1024)) dut0 (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en0),
    .rd_en      (rd_en0),
    .address    (address0),
    .write_data (write_data0),
    .read_data  (read_data0),
    .ready      (ready0),
    .sram_addr  (sram_addr0),
    .sram_dq_out(sram_dq_out0),
    .sram_dq_in (16'h0000),
    .sram_dq_oe (sram_dq_oe0),
    .sram_we_n  (sram_we_n0)
  );

  // Behavioural asynchronous SRAM: combinational read, write while strobe and driver active.
  assign sram_dq_in = mem[sram_addr[5:0]];
  always @(posedge clk) begin
    if (!sram_we_n && sram_dq_oe) mem[sram_addr[5:0]] <= sram_dq_out;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issues one request from a fresh IDLE cycle and records every ready-low cycle after
  // acceptance; returns at the negedge of the DONE cycle with requests dropped.
  task automatic run_access(input logic wr, input logic rd, input logic [31:0] addr,
                            input logic [31:0] data, input logic change,
                            input logic [31:0] alt, output int cnt);
    @(negedge clk);
    wr_en      = wr;
    rd_en      = rd;
    address    = addr;
    write_data = data;
    #1;
    check("ready_fall", ready, 1'b0);
    cnt = 0;
    @(posedge clk);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ready) break;
      rec_addr[cnt] = sram_addr;
      rec_dq[cnt]   = sram_dq_out;
      rec_we[cnt]   = sram_we_n;
      rec_oe[cnt]   = sram_dq_oe;
      cnt++;
      if (change && cnt == 1) address = alt;
    end
    check("access_done", ready, 1'b1);
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
    rst = 1'b1;
    wr_en = 1'b0; rd_en = 1'b0; address = '0; write_data = '0;
    wr_en0 = 1'b0; rd_en0 = 1'b0; address0 = '0; write_data0 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Idle after reset
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_ready", ready, 1'b1);
      check("idle_we_n", sram_we_n, 1'b1);
      check("idle_oe", sram_dq_oe, 1'b0);
      check("idle_rdata", read_data, 32'h0);
    end
    check("idle_addr", sram_addr, 18'd0);

    // Write DEADBEEF at 1028 -> halves 2,3
    run_access(1'b1, 1'b0, 32'd1028, 32'hDEADBEEF, 1'b0, 32'd0, n);
    check("wr_low_cycles", n, 4);
    for (int i = 0; i < 4; i++) begin
      check("wr_addr", rec_addr[i], (i < 2) ? 18'd2 : 18'd3);
      check("wr_dq", rec_dq[i], (i < 2) ? 16'hBEEF : 16'hDEAD);
      check("wr_we_n", rec_we[i], 1'b0);
      check("wr_oe", rec_oe[i], 1'b1);
    end
    check("wr_rdata_kept", read_data, 32'h0);
    check("mem2", mem[2], 16'hBEEF);
    check("mem3", mem[3], 16'hDEAD);

    // Read back 1028
    run_access(1'b0, 1'b1, 32'd1028, 32'd0, 1'b0, 32'd0, n);
    check("rd_low_cycles", n, 4);
    for (int i = 0; i < 4; i++) begin
      check("rd_addr", rec_addr[i], (i < 2) ? 18'd2 : 18'd3);
      check("rd_we_n", rec_we[i], 1'b1);
      check("rd_oe", rec_oe[i], 1'b0);
    end
    check("rd_data", read_data, 32'hDEADBEEF);

    // Simultaneous request is a write
    run_access(1'b1, 1'b1, 32'd1032, 32'h12345678, 1'b0, 32'd0, n);
    check("both_we_n", rec_we[0], 1'b0);
    check("both_mem4", mem[4], 16'h5678);
    check("both_mem5", mem[5], 16'h1234);
    check("both_rdata", read_data, 32'hDEADBEEF);

    // Address changes after acceptance are ignored
    run_access(1'b0, 1'b1, 32'd1032, 32'd0, 1'b1, 32'd2000, n);
    for (int i = 0; i < 4; i++) check("chg_addr", rec_addr[i], (i < 2) ? 18'd4 : 18'd5);
    check("chg_rdata", read_data, 32'h12345678);

    // WAIT_CYCLES=0 stall length
    @(negedge clk);
    wr_en0 = 1'b1;
    address0 = 32'd1028;
    write_data0 = 32'h0BADF00D;
    #1;
    check("w0_ready_fall", ready0, 1'b0);
    @(posedge clk);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ready0) break;
      rec_addr[n] = sram_addr0;
      n++;
    end
    check("w0_low_cycles", n, 2);
    check("w0_addr_lo", rec_addr[0], 18'd2);
    check("w0_addr_hi", rec_addr[1], 18'd3);
    wr_en0 = 1'b0;

    // Reset during HI of a write to 1044 (halves 10,11)
    @(negedge clk);
    wr_en = 1'b1;
    address = 32'd1044;
    write_data = 32'h55AA33CC;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("pre_rst_we_n", sram_we_n, 1'b0);
    check("pre_rst_addr", sram_addr, 18'd11);
    rst = 1'b1;
    wr_en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_we_n", sram_we_n, 1'b1);
    check("rst_oe", sram_dq_oe, 1'b0);
    check("rst_rdata", read_data, 32'h0);
    check("rst_ready", ready, 1'b1);
    check("rst_addr", sram_addr, 18'd0);
    rst = 1'b0;

    run_access(1'b1, 1'b0, 32'd1036, 32'hA5A55A5A, 1'b0, 32'd0, n);
    check("post_wr_addr", rec_addr[3], 18'd7);
    run_access(1'b0, 1'b1, 32'd1036, 32'd0, 1'b0, 32'd0, n);
    check("post_rd_data", read_data, 32'hA5A55A5A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_controller.md
# sram_controller

Multi-cycle data-memory controller for the MEM stage of the 5-stage MIPS pipeline. It replaces the single-cycle data memory: it accepts 32-bit word read/write requests from the EXE/MEM register outputs and performs each one as two 16-bit accesses on an external asynchronous SRAM. While an access is in progress it deasserts `ready`; the hazard/freeze logic uses this to stall every pipeline register until the access completes.

## Interface
- `WAIT_CYCLES`, default 1: extra cycles each SRAM half-access is held. Range 0..7.
- `BASE_ADDR`, default 32'd1024: byte address that maps to SRAM word 0.

- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `wr_en`  in  1  MEM-stage store request.
- `rd_en`  in  1  MEM-stage load request.
- `address`  in  32  byte address from the ALU result; word-aligned.
- `write_data`  in  32  store data.
- `read_data`  out  32  load result, registered.
- `ready`  out  1  high means the pipeline may advance; combinational.
- `sram_addr`  out  18  SRAM half-word address.
- `sram_dq_out`  out  16  SRAM write data.
- `sram_dq_in`  in  16  SRAM read data.
- `sram_dq_oe`  out  1  high drives `sram_dq_out` onto the bus.
- `sram_we_n`  out  1  active-low SRAM write strobe.

## Operation
- Word index `widx = (address - BASE_ADDR) >> 2`. The subtraction is unsigned and 32-bit; an out-of-range address wraps and is not flagged.
- `sram_addr = {widx[16:0], half}`, where half is 0 for bits [15:0] and 1 for bits [31:16].
- FSM states:
  - IDLE: no access in progress.
  - LO: low half-word access.
  - HI: high half-word access.
  - DONE: access complete.
- A wait counter `wcnt` (3 bits) times each LO and HI phase.
- Transitions:
  - IDLE: if `wr_en|rd_en`, latch `address`, `write_data` and the operation type, clear `wcnt`, go to LO. Otherwise stay in IDLE.
  - LO: when `wcnt == WAIT_CYCLES`, go to HI and clear `wcnt`. Otherwise increment `wcnt`.
  - HI: same rule as LO, but the next state is DONE.
  - DONE: always go to IDLE. Requests seen in DONE belong to the instruction that just completed and are ignored.
- If `wr_en` and `rd_en` are both high, the access is a write and `read_data` is unchanged.
- Once a request is accepted, changes on the inputs have no effect until the FSM is back in IDLE. Addressing and data come from the latched copies.
- Write access:
  - LO: `sram_we_n=0`, `sram_dq_oe=1`, `sram_dq_out=wdata[15:0]`.
  - HI: `sram_we_n=0`, `sram_dq_oe=1`, `sram_dq_out=wdata[31:16]`.
  - Every other state: `sram_we_n=1`, `sram_dq_oe=0`.
- Read access:
  - `sram_we_n=1` and `sram_dq_oe=0` throughout.
  - `sram_dq_in` is captured into `read_data[15:0]` on the last cycle of LO.
  - `sram_dq_in` is captured into `read_data[31:16]` on the last cycle of HI.
  - `read_data` holds its value until the next read completes.
- `ready` is:
  - `!(wr_en|rd_en)` in IDLE;
  - 0 in LO and HI;
  - 1 in DONE.
- `sram_addr` is registered-equivalent. It is 0 in IDLE and DONE, and driven from the latched address in LO and HI.

## Timing
- Reset values:
  - state IDLE, `wcnt=0`;
  - `read_data=0`;
  - `sram_addr=0`, `sram_dq_out=0`, `sram_dq_oe=0`, `sram_we_n=1`;
  - `ready = !(wr_en|rd_en)`.
- Reset asserted mid-access returns the FSM to IDLE on that edge.
  - The SRAM write is abandoned and the SRAM contents are undefined.
  - `read_data` is cleared.
- Stall length for one access is 2*(WAIT_CYCLES+1) cycles with `ready` low, followed by 1 DONE cycle with `ready` high.
  - With WAIT_CYCLES=1: `ready` is low for 4 cycles.
  - With WAIT_CYCLES=0: `ready` is low for 2 cycles.
- `ready` falls in the same cycle a request first appears in IDLE, so the pipeline never advances past an unserviced request.
- Back-to-back requests: the next request is accepted in the IDLE cycle after DONE.

## Test plan
- Idle, reset then `rd_en=wr_en=0` for 5 cycles -> `ready=1`, `sram_we_n=1`, `sram_dq_oe=0`, `read_data=0`.
- Write, WAIT_CYCLES=1, `wr_en` with `address=1028`, `write_data=32'hDEADBEEF` -> expect all of:
  - `sram_addr=2` with `dq_out=16'hBEEF` and `we_n=0` for 2 cycles;
  - then `sram_addr=3` with `dq_out=16'hDEAD` for 2 cycles;
  - `ready` low for exactly 4 cycles, high in the 5th.
- Read-back, `rd_en` at `address=1028` with a behavioural SRAM model -> `read_data=32'hDEADBEEF` in DONE, and `we_n` stays 1 throughout.
- Simultaneous requests, `rd_en=wr_en=1`, `address=1032`, `write_data=32'h12345678` -> SRAM halves 4 and 5 written with 5678 and 1234; `read_data` still 32'hDEADBEEF.
- Input changes, `address` changed to 2000 one cycle after acceptance -> `sram_addr` stays 4/5. Separately, WAIT_CYCLES=0 -> `ready` is low for exactly 2 cycles.
- Reset mid-access, `rst` pulsed during HI of a write -> next cycle state is IDLE with `we_n=1`, `dq_oe=0`, `read_data=0`, and `ready=1` with requests low; a subsequent write then read of 1036 returns the written value.
